// File: rtl/sram_arbiter.sv
//------------------------------------------------------------------------------
// Module   : sram_arbiter
// Purpose  : Two-port round-robin arbiter in front of a single-port 16K x 16
//            SRAM with nibble write mask and one-cycle read latency. Optionally
//            zero-fills the whole SRAM after reset before serving requests.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sram_arbiter #(
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,

  input  logic        a_req_valid,
  output logic        a_req_ready,
  input  logic [13:0] a_req_addr,
  input  logic        a_req_write,
  input  logic [3:0]  a_req_mask,
  input  logic [15:0] a_req_data,
  output logic        a_rsp_valid,
  output logic [15:0] a_rsp_data,

  input  logic        b_req_valid,
  output logic        b_req_ready,
  input  logic [13:0] b_req_addr,
  input  logic        b_req_write,
  input  logic [3:0]  b_req_mask,
  input  logic [15:0] b_req_data,
  output logic        b_rsp_valid,
  output logic [15:0] b_rsp_data,

  output logic [13:0] sram_addr,
  output logic        sram_write_enable,
  output logic [3:0]  sram_write_mask,
  output logic [15:0] sram_data_inp,
  input  logic [15:0] sram_data_out,

  output logic        init_done
);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  // Last-grant encoding: B at reset so that A wins the first tie.
  localparam logic LG_A = 1'b0;
  localparam logic LG_B = 1'b1;

  localparam logic [13:0] CLR_LAST = 14'h3FFF;

  localparam state_t RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

  state_t      state_q, state_d;
  logic [13:0] clr_cnt_q, clr_cnt_d;
  logic        last_q, last_d;
  logic        a_rsp_q, a_rsp_d;
  logic        b_rsp_q, b_rsp_d;

  logic        w_run;
  logic        w_clear;
  logic        w_grant_a;
  logic        w_grant_b;

  // Mode qualification: every output is forced idle while reset is held.
  always_comb begin
    w_run   = reset_n && (state_q == ST_RUN);
    w_clear = reset_n && (state_q == ST_CLEAR);
  end

  // Round-robin grant: a lone requester wins, a tie goes to the port not granted last.
  always_comb begin
    w_grant_a = w_run && a_req_valid && (!b_req_valid || (last_q == LG_B));
    w_grant_b = w_run && b_req_valid && (!a_req_valid || (last_q == LG_A));
  end

  // SRAM pin mux: clear writes, then the granted port; reads carry no mask or data.
  always_comb begin
    sram_addr         = '0;
    sram_write_enable = 1'b0;
    sram_write_mask   = '0;
    sram_data_inp     = '0;
    if (w_clear) begin
      sram_addr         = clr_cnt_q;
      sram_write_enable = 1'b1;
      sram_write_mask   = 4'hF;
      sram_data_inp     = '0;
    end else if (w_grant_a) begin
      sram_addr         = a_req_addr;
      sram_write_enable = a_req_write;
      sram_write_mask   = a_req_write ? a_req_mask : 4'h0;
      sram_data_inp     = a_req_write ? a_req_data : 16'h0000;
    end else if (w_grant_b) begin
      sram_addr         = b_req_addr;
      sram_write_enable = b_req_write;
      sram_write_mask   = b_req_write ? b_req_mask : 4'h0;
      sram_data_inp     = b_req_write ? b_req_data : 16'h0000;
    end
  end

  // Next-state: clear sweep, last-grant on accepted transfers, read-response tracking.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    last_d    = last_q;
    a_rsp_d   = w_grant_a && !a_req_write;
    b_rsp_d   = w_grant_b && !b_req_write;
    if (state_q == ST_CLEAR) begin
      clr_cnt_d = clr_cnt_q + 14'd1;
      if (clr_cnt_q == CLR_LAST) begin
        state_d = ST_RUN;
      end
    end
    if (w_grant_a) begin
      last_d = LG_A;
    end else if (w_grant_b) begin
      last_d = LG_B;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= RESET_STATE;
      clr_cnt_q <= '0;
      last_q    <= LG_B;
      a_rsp_q   <= 1'b0;
      b_rsp_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      last_q    <= last_d;
      a_rsp_q   <= a_rsp_d;
      b_rsp_q   <= b_rsp_d;
    end
  end

  // Handshake and response outputs; response data is zero outside its valid cycle.
  always_comb begin
    a_req_ready = w_grant_a;
    b_req_ready = w_grant_b;
    init_done   = w_run;
    a_rsp_valid = a_rsp_q;
    b_rsp_valid = b_rsp_q;
    a_rsp_data  = a_rsp_q ? sram_data_out : 16'h0000;
    b_rsp_data  = b_rsp_q ? sram_data_out : 16'h0000;
  end

endmodule

`default_nettype wire

// File: tb/tb_sram_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_sram_arbiter
// Purpose  : Self-checking bench for sram_arbiter with an SRAM model and a
//            transaction-level reference (grant rule, memory image, pending
//            responses).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sram_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        a_req_valid, a_req_ready, a_req_write, a_rsp_valid;
  logic [13:0] a_req_addr;
  logic [3:0]  a_req_mask;
  logic [15:0] a_req_data, a_rsp_data;
  logic        b_req_valid, b_req_ready, b_req_write, b_rsp_valid;
  logic [13:0] b_req_addr;
  logic [3:0]  b_req_mask;
  logic [15:0] b_req_data, b_rsp_data;
  logic [13:0] sram_addr;
  logic        sram_write_enable;
  logic [3:0]  sram_write_mask;
  logic [15:0] sram_data_inp, sram_data_out;
  logic        init_done;

  always #5 clock = ~clock;

  sram_arbiter #(.CLEAR_ON_RESET(1'b1)) dut (
    .clock(clock), .reset_n(reset_n),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_addr(a_req_addr),
    .a_req_write(a_req_write), .a_req_mask(a_req_mask), .a_req_data(a_req_data),
    .a_rsp_valid(a_rsp_valid), .a_rsp_data(a_rsp_data),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_addr(b_req_addr),
    .b_req_write(b_req_write), .b_req_mask(b_req_mask), .b_req_data(b_req_data),
    .b_rsp_valid(b_rsp_valid), .b_rsp_data(b_rsp_data),
    .sram_addr(sram_addr), .sram_write_enable(sram_write_enable),
    .sram_write_mask(sram_write_mask), .sram_data_inp(sram_data_inp),
    .sram_data_out(sram_data_out), .init_done(init_done)
  );

  function automatic logic [15:0] nib_merge(input logic [15:0] old_v, input logic [15:0] new_v,
                                            input logic [3:0] m);
    logic [15:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) if (m[i]) r[i*4 +: 4] = new_v[i*4 +: 4];
    return r;
  endfunction

  // SRAM model: masked write, registered read data one cycle after the address.
  logic [15:0] sram_mem [16384];
  always @(posedge clock) begin
    if (sram_write_enable)
      sram_mem[sram_addr] <= nib_merge(sram_mem[sram_addr], sram_data_inp, sram_write_mask);
    sram_data_out <= sram_mem[sram_addr];
  end

  // Reference model state
  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] shadow [16384];
  bit          lg_b;          // 1 = B was granted last
  bit          pa, pb;        // read response expected this cycle
  logic [15:0] pa_d, pb_d;

  // Staged stimulus applied at the next falling edge
  logic        s_av, s_aw, s_bv, s_bw;
  logic [13:0] s_aa, s_ba;
  logic [3:0]  s_am, s_bm;
  logic [15:0] s_ad, s_bd;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pins();
    return {29'd0, sram_write_enable, sram_write_mask, sram_data_inp, sram_addr};
  endfunction

  function automatic logic [63:0] ctl();
    return {59'd0, a_req_ready, b_req_ready, init_done, a_rsp_valid, b_rsp_valid};
  endfunction

  task automatic set_a(input logic v, input logic w, input logic [13:0] ad,
                       input logic [3:0] m, input logic [15:0] d);
    s_av = v; s_aw = w; s_aa = ad; s_am = m; s_ad = d;
  endtask

  task automatic set_b(input logic v, input logic w, input logic [13:0] ad,
                       input logic [3:0] m, input logic [15:0] d);
    s_bv = v; s_bw = w; s_ba = ad; s_bm = m; s_bd = d;
  endtask

  // One RUN cycle: apply staged inputs, check against the model, advance the model.
  // g: 0 = no grant, 1 = A, 2 = B
  task automatic tick(output int g);
    logic [13:0] ea;
    logic        ew;
    logic [3:0]  em;
    logic [15:0] ed;
    @(negedge clock);
    a_req_valid = s_av; a_req_write = s_aw; a_req_addr = s_aa; a_req_mask = s_am; a_req_data = s_ad;
    b_req_valid = s_bv; b_req_write = s_bw; b_req_addr = s_ba; b_req_mask = s_bm; b_req_data = s_bd;
    #1;
    if (s_av && s_bv) g = lg_b ? 1 : 2;
    else if (s_av)    g = 1;
    else if (s_bv)    g = 2;
    else              g = 0;
    chk("ready_a", a_req_ready, g == 1);
    chk("ready_b", b_req_ready, g == 2);
    chk("init_done", init_done, 1);
    chk("rsp_a", {a_rsp_valid, a_rsp_data}, {pa, pa ? pa_d : 16'h0});
    chk("rsp_b", {b_rsp_valid, b_rsp_data}, {pb, pb ? pb_d : 16'h0});
    ea = 0; ew = 0; em = 0; ed = 0;
    if (g == 1) begin ea = s_aa; ew = s_aw; em = s_aw ? s_am : 4'h0; ed = s_aw ? s_ad : 16'h0; end
    if (g == 2) begin ea = s_ba; ew = s_bw; em = s_bw ? s_bm : 4'h0; ed = s_bw ? s_bd : 16'h0; end
    chk("sram_pins", pins(), {29'd0, ew, em, ed, ea});
    pa = 0; pb = 0;
    if (g != 0) begin
      if (ew) shadow[ea] = nib_merge(shadow[ea], ed, em);
      else if (g == 1) begin pa = 1; pa_d = shadow[ea]; end
      else begin pb = 1; pb_d = shadow[ea]; end
      lg_b = (g == 2);
    end
  endtask

  // Hold reset for a few cycles with both ports requesting; everything must stay idle.
  task automatic hold_reset();
    reset_n = 1'b0;
    lg_b = 1; pa = 0; pb = 0;
    a_req_valid = 1; a_req_write = 0; b_req_valid = 1; b_req_write = 1;
    b_req_mask = 4'hF; b_req_data = 16'h5555;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock); #1;
      chk("rst_ctl", ctl(), 0);
      chk("rst_pins", pins(), 0);
    end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  // Walk the clear sweep (inputs keep requesting); stop early at stop_at if < 16384.
  task automatic run_clear(input int stop_at);
    for (int i = 0; i < 16384; i++) begin
      if (i > 0) @(negedge clock);
      #1;
      chk("clr_pins", pins(), {29'd0, 1'b1, 4'hF, 16'h0, 14'(i)});
      chk("clr_ctl", ctl(), 0);
      if (i == stop_at) return;
    end
    for (int i = 0; i < 16384; i++) shadow[i] = 16'h0;
  endtask

  initial begin
    int g;
    reset_n = 1'b1;
    set_a(0, 0, 0, 0, 0);
    set_b(0, 0, 0, 0, 0);
    a_req_addr = 14'h0100; a_req_mask = 0; a_req_data = 0;
    b_req_addr = 14'h0200;
    #1;

    // Power-up reset and full clear; the first RUN cycle must be idle with init_done.
    hold_reset();
    run_clear(16384);
    tick(g);

    // A writes BEEF, B reads it back on the next cycle.
    set_a(1, 1, 14'h0010, 4'hF, 16'hBEEF); tick(g); chk("beef_wr_g", g, 1);
    set_a(0, 0, 0, 0, 0);
    set_b(1, 0, 14'h0010, 4'h0, 16'h0);     tick(g); chk("beef_rd_g", g, 2);
    set_b(0, 0, 0, 0, 0);                   tick(g);
    chk("beef_rsp_b", {b_rsp_valid, b_rsp_data}, {1'b1, 16'hBEEF});
    chk("beef_rsp_a", a_rsp_valid, 0);

    // Both ports held valid: strict alternation starting with A.
    for (int k = 0; k < 6; k++) begin
      set_a(1, 0, 14'($urandom_range(0, 63)), 0, 0);
      set_b(1, 0, 14'($urandom_range(0, 63)), 0, 0);
      tick(g);
      chk("alternate", g, (k % 2 == 0) ? 1 : 2);
    end

    // Only B for three cycles, then a tie goes to A.
    set_a(0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      set_b(1, 0, 14'(k), 0, 0);
      tick(g);
      chk("b_only", g, 2);
    end
    set_a(1, 0, 14'h0005, 0, 0);
    set_b(1, 0, 14'h0006, 0, 0);
    tick(g); chk("tie_after_b", g, 1);

    // Nibble-masked overwrite.
    set_b(0, 0, 0, 0, 0);
    set_a(1, 1, 14'h0123, 4'hF, 16'h1234); tick(g);
    set_a(1, 1, 14'h0123, 4'h3, 16'hABCD); tick(g);
    set_a(1, 0, 14'h0123, 4'h0, 16'h0);    tick(g);
    set_a(0, 0, 0, 0, 0);                  tick(g);
    chk("mask_rd", {a_rsp_valid, a_rsp_data}, {1'b1, 16'h12CD});

    // Randomized traffic over a small address window to force read-after-write hits.
    for (int k = 0; k < 400; k++) begin
      set_a(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 14'($urandom_range(0, 15)),
            4'($urandom), 16'($urandom));
      set_b(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 14'($urandom_range(0, 15)),
            4'($urandom), 16'($urandom));
      tick(g);
    end

    // A read accepted just before reset must never respond.
    set_a(1, 0, 14'h0003, 0, 0);
    set_b(0, 0, 0, 0, 0);
    tick(g); chk("pre_rst_rd", g, 1);
    #1;
    hold_reset();

    // Interrupt the clear at address 5000; it must restart from 0 and complete.
    run_clear(5000);
    #1;
    hold_reset();
    run_clear(16384);
    set_a(0, 0, 0, 0, 0);
    tick(g);

    // Clear left zeros behind: read a previously written address.
    set_b(1, 0, 14'h0010, 0, 0); tick(g);
    set_b(0, 0, 0, 0, 0);        tick(g);
    chk("post_clr_rd", {b_rsp_valid, b_rsp_data}, {1'b1, 16'h0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 The module SHALL have parameter CLEAR_ON_RESET, default 1: when 1, zero-fill the whole SRAM after reset before serving requests.
REQ-002 The module SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have ports a_req_valid (input, 1) and a_req_ready (output, 1): port A request handshake.
REQ-005 The module SHALL have ports a_req_addr (input, 14), a_req_write (input, 1), a_req_mask (input, 4) and a_req_data (input, 16): port A word address, write flag, nibble write mask and write data.
REQ-006 The module SHALL have ports a_rsp_valid (output, 1) and a_rsp_data (output, 16): port A read response.
REQ-007 The module SHALL have port B ports b_req_valid, b_req_ready, b_req_addr, b_req_write, b_req_mask, b_req_data, b_rsp_valid and b_rsp_data, with the same directions, widths and meanings as port A.
REQ-008 The module SHALL have SRAM-side ports sram_addr (output, 14), sram_write_enable (output, 1), sram_write_mask (output, 4), sram_data_inp (output, 16) and sram_data_out (input, 16), with sram_data_out valid one cycle after a read address is presented.
REQ-009 The module SHALL have port init_done, output, 1 bit: high once the module serves requests.

Function
REQ-010 The module SHALL implement states CLEAR and RUN.
REQ-011 On reset the module SHALL enter CLEAR if CLEAR_ON_RESET=1, else RUN.
REQ-012 In CLEAR the module SHALL hold a 14-bit clear counter starting at 0 and, each cycle, drive sram_addr=counter, sram_write_enable=1, sram_write_mask=4'hF, sram_data_inp=0, then increment the counter.
REQ-013 CLEAR SHALL move to RUN on the cycle after the write to address 16383; the counter wraps to 0, for exactly 16384 clear writes.
REQ-014 In CLEAR, a_req_ready and b_req_ready SHALL be 0 and init_done SHALL be 0.
REQ-015 In RUN, init_done SHALL be 1.
REQ-016 In RUN, x_req_ready SHALL be combinational: 1 iff x is granted this cycle; a port is granted only if its req_valid=1.
REQ-017 Arbitration SHALL be round-robin using a 1-bit last-grant register, reset to B so that A wins the first tie.
REQ-018 If only one port is valid, that port SHALL be granted.
REQ-019 If both ports are valid, the port not equal to last-grant SHALL be granted.
REQ-020 last-grant SHALL update only on an accepted transfer (valid and ready).
REQ-021 When a port is accepted in cycle T, sram_addr, sram_write_enable (=req_write), sram_write_mask and sram_data_inp SHALL be driven combinationally from that port in cycle T.
REQ-022 For a read, sram_write_mask and sram_data_inp SHALL be 0.
REQ-023 With no transfer in RUN, sram_write_enable, sram_addr, sram_write_mask and sram_data_inp SHALL all be 0.
REQ-024 An accepted read in cycle T SHALL produce x_rsp_valid=1 for exactly cycle T+1, with x_rsp_data=sram_data_out.
REQ-025 Writes SHALL produce no response.
REQ-026 x_rsp_data SHALL be 0 whenever x_rsp_valid=0.
REQ-027 Back-to-back reads SHALL sustain one accepted request per cycle, and responses SHALL return in acceptance order.
REQ-028 A write to an address followed by a read of the same address on the next cycle SHALL return the written data, subject to the mask.
REQ-029 At most one request SHALL be accepted per cycle, and accepted requests SHALL never be dropped.

Reset
REQ-030 Asserting reset_n=0 SHALL, asynchronously: set the state to CLEAR (or RUN per CLEAR_ON_RESET), clear the counter, set last-grant=B, force a_rsp_valid=b_rsp_valid=0 and init_done=0, and drive all ready and sram_* outputs to 0 while reset is held.
REQ-031 Reset during CLEAR SHALL restart the clear from address 0.
REQ-032 A read pending a response when reset is asserted SHALL produce no response.

Verification
REQ-033 The bench SHALL cover: CLEAR_ON_RESET=1, release reset -> exactly 16384 writes of 0 with mask F at addresses 0..16383; init_done rises the next cycle; readies stay 0 throughout.
REQ-034 The bench SHALL cover: A writes 0xBEEF at 0x0010 mask F; B reads 0x0010 next cycle -> b_rsp_valid one cycle later with data 0xBEEF; a_rsp_valid stays 0.
REQ-035 The bench SHALL cover: A and B hold valid for 6 cycles -> grants alternate A,B,A,B,A,B.
REQ-036 The bench SHALL cover: only B valid for 3 cycles, then both valid -> B,B,B, then A.
REQ-037 The bench SHALL cover: write 0x1234 mask F, then 0xABCD mask 4'b0011 to the same address, then read -> 0x12CD.
REQ-038 The bench SHALL cover: assert reset at clear address 5000 -> the clear restarts at 0, and no response pulses appear.
